// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - engine request/grant/command signals and SDRAM pins around the arbiter
interface sdram_arbit_if #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2
);
  // init engine
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  // auto-refresh engine
  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;
  // write engine
  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] wr_bank;
  logic              wr_en;
  // read engine
  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BANK_W-1:0] rd_bank;
  logic              rd_en;
  // SDRAM pins and status
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BANK_W-1:0] sdram_bank;
  logic [2:0]        busy_state;
  logic              err_timeout;

  // arbiter side
  modport slave (
    input  init_end, init_cmd, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output aref_en, wr_en, rd_en,
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_addr, sdram_bank, busy_state, err_timeout
  );

  // engines / pin observer side
  modport master (
    output init_end, init_cmd, init_addr,
    output aref_req, aref_end, aref_cmd, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  aref_en, wr_en, rd_en,
    input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_addr, sdram_bank, busy_state, err_timeout
  );
endinterface

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter: init, refresh, write/read grant and pin mux
module sdram_arbit #(
  parameter int ADDR_W   = 12,
  parameter int BANK_W   = 2,
  parameter int BUSY_MAX = 2047
) (
  input  logic         i_sclk,
  input  logic         i_rst,
  sdram_arbit_if.slave io_bus
);

  localparam int              CNT_W   = (BUSY_MAX < 1) ? 1 : $clog2(BUSY_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_MAX);
  localparam logic [3:0]      CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_aref_en;
  logic              r_wr_en;
  logic              r_rd_en;
  logic              r_last_rd;     // 1 = last write/read grant went to the reader
  logic [CNT_W-1:0]  r_busy_cnt;
  logic [CNT_W-1:0]  w_busy_inc;
  logic              r_err;
  logic              w_leave_arbit;
  logic              w_in_service;
  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [BANK_W-1:0] w_bank;

  // next-state: init first, then refresh, then write/read alternating on contention
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (io_bus.init_end) w_state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (io_bus.aref_req)                     w_state_nxt = ST_AREF;
        else if (io_bus.wr_req && io_bus.rd_req) w_state_nxt = r_last_rd ? ST_WRITE : ST_READ;
        else if (io_bus.wr_req)                  w_state_nxt = ST_WRITE;
        else if (io_bus.rd_req)                  w_state_nxt = ST_READ;
      end
      ST_AREF: begin
        if (io_bus.aref_end) w_state_nxt = ST_ARBIT;
      end
      ST_WRITE: begin
        if (io_bus.wr_end) w_state_nxt = ST_ARBIT;
      end
      ST_READ: begin
        if (io_bus.rd_end) w_state_nxt = ST_ARBIT;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_leave_arbit = (r_state == ST_ARBIT) && (w_state_nxt != ST_ARBIT);
  assign w_in_service  = (r_state == ST_AREF) || (r_state == ST_WRITE) || (r_state == ST_READ);
  assign w_busy_inc    = (r_busy_cnt == CNT_MAX) ? r_busy_cnt : r_busy_cnt + CNT_W'(1);

  // state register plus one-cycle grant pulses issued on the edge that leaves ARBIT
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_state   <= ST_INIT;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_last_rd <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_aref_en <= w_leave_arbit && (w_state_nxt == ST_AREF);
      r_wr_en   <= w_leave_arbit && (w_state_nxt == ST_WRITE);
      r_rd_en   <= w_leave_arbit && (w_state_nxt == ST_READ);
      if (w_leave_arbit && (w_state_nxt == ST_WRITE)) r_last_rd <= 1'b0;
      if (w_leave_arbit && (w_state_nxt == ST_READ))  r_last_rd <= 1'b1;
    end
  end

  // busy watchdog: restart on each grant, count while serving, sticky error at the limit
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_busy_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_leave_arbit) begin
      r_busy_cnt <= '0;
    end else if (w_in_service) begin
      r_busy_cnt <= w_busy_inc;
      if (w_busy_inc == CNT_MAX) r_err <= 1'b1;
    end
  end

  // zero-latency mux of the owning engine's command onto the pins
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    w_bank = '0;
    case (r_state)
      ST_INIT: begin
        w_cmd  = io_bus.init_cmd;
        w_addr = io_bus.init_addr;
      end
      ST_AREF: begin
        w_cmd  = io_bus.aref_cmd;
        w_addr = io_bus.aref_addr;
      end
      ST_WRITE: begin
        w_cmd  = io_bus.wr_cmd;
        w_addr = io_bus.wr_addr;
        w_bank = io_bus.wr_bank;
      end
      ST_READ: begin
        w_cmd  = io_bus.rd_cmd;
        w_addr = io_bus.rd_addr;
        w_bank = io_bus.rd_bank;
      end
      default: begin
        w_cmd  = CMD_NOP;
        w_addr = '0;
        w_bank = '0;
      end
    endcase
  end

  assign io_bus.sdram_cs_n  = w_cmd[3];
  assign io_bus.sdram_ras_n = w_cmd[2];
  assign io_bus.sdram_cas_n = w_cmd[1];
  assign io_bus.sdram_we_n  = w_cmd[0];
  assign io_bus.sdram_addr  = w_addr;
  assign io_bus.sdram_bank  = w_bank;
  assign io_bus.aref_en     = r_aref_en;
  assign io_bus.wr_en       = r_wr_en;
  assign io_bus.rd_en       = r_rd_en;
  assign io_bus.busy_state  = r_state;
  assign io_bus.err_timeout = r_err;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed self-checking bench for sdram_arbit
module tb_sdram_arbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  sdram_arbit_if #(.ADDR_W(12), .BANK_W(2)) bus();

  sdram_arbit #(.ADDR_W(12), .BANK_W(2), .BUSY_MAX(15)) dut (
    .i_sclk (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  wire [3:0] pins = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
  wire [2:0] ens  = {bus.aref_en, bus.wr_en, bus.rd_en};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.init_end = 1'b0; bus.init_cmd = 4'b0111; bus.init_addr = '0;
    bus.aref_req = 1'b0; bus.aref_end = 1'b0; bus.aref_cmd = 4'b0111; bus.aref_addr = '0;
    bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_cmd = 4'b0111; bus.wr_addr = '0; bus.wr_bank = '0;
    bus.rd_req = 1'b0; bus.rd_end = 1'b0; bus.rd_cmd = 4'b0111; bus.rd_addr = '0; bus.rd_bank = '0;
  endtask

  task automatic reset_to_arbit();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.init_end = 1'b1;
    tick();
    bus.init_end = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.init_cmd  = 4'b0010;
    bus.init_addr = 12'h400;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.busy_state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d exp 0", bus.busy_state); end
    n_checks++; if (ens !== 3'b000) begin n_errors++; $display("FAIL reset_enables: got %b exp 000", ens); end
    n_checks++; if (bus.err_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b exp 0", bus.err_timeout); end
    n_checks++; if (pins !== 4'b0010) begin n_errors++; $display("FAIL init_pins: got %b exp 0010", pins); end
    n_checks++; if (bus.sdram_addr !== 12'h400) begin n_errors++; $display("FAIL init_addr: got %h exp 400", bus.sdram_addr); end
    tick();
    n_checks++; if (bus.busy_state !== 3'd0) begin n_errors++; $display("FAIL init_hold: got %0d exp 0", bus.busy_state); end
    bus.init_end = 1'b1;
    tick();
    bus.init_end = 1'b0;
    n_checks++; if (bus.busy_state !== 3'd1) begin n_errors++; $display("FAIL init_to_arbit: got %0d exp 1", bus.busy_state); end
    n_checks++; if (pins !== 4'b0111) begin n_errors++; $display("FAIL arbit_nop: got %b exp 0111", pins); end
    n_checks++; if (bus.sdram_addr !== 12'h000) begin n_errors++; $display("FAIL arbit_addr: got %h exp 000", bus.sdram_addr); end
  endtask

  task automatic test_single_write();
    bus.wr_cmd  = 4'b0100;
    bus.wr_addr = 12'h01C;
    bus.wr_bank = 2'd2;
    bus.wr_req  = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    n_checks++; if (bus.busy_state !== 3'd3) begin n_errors++; $display("FAIL wr_state: got %0d exp 3", bus.busy_state); end
    n_checks++; if (ens !== 3'b010) begin n_errors++; $display("FAIL wr_grant: got %b exp 010", ens); end
    n_checks++; if (pins !== 4'b0100) begin n_errors++; $display("FAIL wr_pins: got %b exp 0100", pins); end
    n_checks++; if (bus.sdram_addr !== 12'h01C) begin n_errors++; $display("FAIL wr_addr: got %h exp 01c", bus.sdram_addr); end
    n_checks++; if (bus.sdram_bank !== 2'd2) begin n_errors++; $display("FAIL wr_bank: got %0d exp 2", bus.sdram_bank); end
    bus.rd_end = 1'b1; bus.aref_end = 1'b1;
    tick();
    bus.rd_end = 1'b0; bus.aref_end = 1'b0;
    n_checks++; if (ens !== 3'b000) begin n_errors++; $display("FAIL wr_en_one_cycle: got %b exp 000", ens); end
    n_checks++; if (bus.busy_state !== 3'd3) begin n_errors++; $display("FAIL foreign_end_ignored: got %0d exp 3", bus.busy_state); end
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    n_checks++; if (bus.busy_state !== 3'd1) begin n_errors++; $display("FAIL wr_end_arbit: got %0d exp 1", bus.busy_state); end
    n_checks++; if (ens !== 3'b000) begin n_errors++; $display("FAIL wr_end_no_grant: got %b exp 000", ens); end
    tick();
    n_checks++; if (bus.busy_state !== 3'd1) begin n_errors++; $display("FAIL idle_arbit: got %0d exp 1", bus.busy_state); end
  endtask

  task automatic test_priority();
    reset_to_arbit();
    bus.aref_cmd = 4'b0001; bus.aref_addr = 12'h400;
    bus.wr_bank = 2'd3;
    bus.rd_cmd = 4'b0101; bus.rd_addr = 12'h2A5; bus.rd_bank = 2'd1;
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    tick();
    bus.aref_req = 1'b0;
    n_checks++; if (bus.busy_state !== 3'd2) begin n_errors++; $display("FAIL prio_aref_state: got %0d exp 2", bus.busy_state); end
    n_checks++; if (ens !== 3'b100) begin n_errors++; $display("FAIL prio_aref_grant: got %b exp 100", ens); end
    n_checks++; if ({pins, bus.sdram_addr, bus.sdram_bank} !== {4'b0001, 12'h400, 2'd0}) begin n_errors++; $display("FAIL aref_mux: got %b/%h/%0d exp 0001/400/0", pins, bus.sdram_addr, bus.sdram_bank); end
    bus.aref_end = 1'b1;
    tick();
    bus.aref_end = 1'b0;
    n_checks++; if ({bus.busy_state, ens} !== {3'd1, 3'b000}) begin n_errors++; $display("FAIL aref_end_arbit: got %0d/%b exp 1/000", bus.busy_state, ens); end
    tick();
    n_checks++; if ({bus.busy_state, ens} !== {3'd3, 3'b010}) begin n_errors++; $display("FAIL prio_write_second: got %0d/%b exp 3/010", bus.busy_state, ens); end
    bus.wr_req = 1'b0;
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    tick();
    n_checks++; if ({bus.busy_state, ens} !== {3'd4, 3'b001}) begin n_errors++; $display("FAIL prio_read_third: got %0d/%b exp 4/001", bus.busy_state, ens); end
    n_checks++; if ({pins, bus.sdram_addr, bus.sdram_bank} !== {4'b0101, 12'h2A5, 2'd1}) begin n_errors++; $display("FAIL rd_mux: got %b/%h/%0d exp 0101/2a5/1", pins, bus.sdram_addr, bus.sdram_bank); end
    bus.rd_req = 1'b0;
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    n_checks++; if (bus.busy_state !== 3'd1) begin n_errors++; $display("FAIL rd_end_arbit: got %0d exp 1", bus.busy_state); end
  endtask

  task automatic test_alternation();
    bit exp_wr;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_wr = (i % 2 == 0);
      tick();
      n_checks++; if (bus.busy_state !== (exp_wr ? 3'd3 : 3'd4)) begin n_errors++; $display("FAIL alt_state_%0d: got %0d exp %0d", i, bus.busy_state, exp_wr ? 3 : 4); end
      n_checks++; if (ens !== (exp_wr ? 3'b010 : 3'b001)) begin n_errors++; $display("FAIL alt_grant_%0d: got %b exp %b", i, ens, exp_wr ? 3'b010 : 3'b001); end
      tick();
      if (exp_wr) bus.wr_end = 1'b1; else bus.rd_end = 1'b1;
      tick();
      bus.wr_end = 1'b0; bus.rd_end = 1'b0;
      n_checks++; if ({bus.busy_state, ens} !== {3'd1, 3'b000}) begin n_errors++; $display("FAIL alt_gap_%0d: got %0d/%b exp 1/000", i, bus.busy_state, ens); end
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic test_no_preempt();
    bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    repeat (9) tick();
    bus.aref_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if ({bus.busy_state, bus.aref_en} !== {3'd3, 1'b0}) begin n_errors++; $display("FAIL no_preempt_%0d: got %0d/%b exp 3/0", i, bus.busy_state, bus.aref_en); end
    end
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    n_checks++; if ({bus.busy_state, ens} !== {3'd1, 3'b000}) begin n_errors++; $display("FAIL preempt_end_arbit: got %0d/%b exp 1/000", bus.busy_state, ens); end
    tick();
    n_checks++; if ({bus.busy_state, ens} !== {3'd2, 3'b100}) begin n_errors++; $display("FAIL aref_after_write: got %0d/%b exp 2/100", bus.busy_state, ens); end
    bus.aref_req = 1'b0;
    bus.aref_end = 1'b1;
    tick();
    bus.aref_end = 1'b0;
    n_checks++; if (bus.err_timeout !== 1'b0) begin n_errors++; $display("FAIL err_below_limit: got %b exp 0", bus.err_timeout); end
  endtask

  task automatic test_timeout_reset();
    reset_to_arbit();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    n_checks++; if (bus.rd_en !== 1'b1) begin n_errors++; $display("FAIL to_rd_grant: got %b exp 1", bus.rd_en); end
    repeat (14) tick();
    n_checks++; if ({bus.busy_state, bus.err_timeout} !== {3'd4, 1'b0}) begin n_errors++; $display("FAIL err_edge14: got %0d/%b exp 4/0", bus.busy_state, bus.err_timeout); end
    tick();
    n_checks++; if ({bus.busy_state, bus.err_timeout} !== {3'd4, 1'b1}) begin n_errors++; $display("FAIL err_edge15: got %0d/%b exp 4/1", bus.busy_state, bus.err_timeout); end
    repeat (5) tick();
    n_checks++; if ({bus.busy_state, bus.err_timeout, ens} !== {3'd4, 1'b1, 3'b000}) begin n_errors++; $display("FAIL err_sticky: got %0d/%b/%b exp 4/1/000", bus.busy_state, bus.err_timeout, ens); end
    rst = 1'b1;
    tick();
    n_checks++; if ({bus.busy_state, bus.err_timeout, ens} !== {3'd0, 1'b0, 3'b000}) begin n_errors++; $display("FAIL mid_reset: got %0d/%b/%b exp 0/0/000", bus.busy_state, bus.err_timeout, ens); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_priority();
    test_alternation();
    test_no_preempt();
    test_timeout_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Central SDRAM command arbiter, directly upstream of the write engine and its peer read and auto-refresh engines.
- Grants the bus to one engine at a time using enable pulses, and tracks completion through the engines' end pulses.
- Muxes the granted engine's cmd/addr/bank onto the SDRAM pins and decodes the command into the cs_n/ras_n/cas_n/we_n pin signals.
- Priority order: initialisation, then refresh, then write/read. Write and read alternate when both are pending.

Parameters:
- ADDR_W, 12, SDRAM address width.
- BANK_W, 2, bank address width.
- BUSY_MAX, 2047, maximum cycles a service state may hold the bus before err_timeout is raised.

Ports:
- sclk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- init_end  in  1  level; init sequence complete
- init_cmd  in  4  init engine cmd {cs_n,ras_n,cas_n,we_n}
- init_addr  in  ADDR_W  init engine address
- aref_req  in  1  refresh request (level)
- aref_end  in  1  refresh done (1-cycle pulse)
- aref_cmd  in  4  refresh engine cmd
- aref_addr  in  ADDR_W  refresh engine address
- aref_en  out  1  refresh grant (1-cycle pulse)
- wr_req  in  1  write request (level; cleared by writer on wr_en)
- wr_end  in  1  write burst/segment done (pulse)
- wr_cmd  in  4  write engine cmd
- wr_addr  in  ADDR_W  write engine address
- wr_bank  in  BANK_W  write engine bank
- wr_en  out  1  write grant (1-cycle pulse)
- rd_req  in  1  read request (level)
- rd_end  in  1  read done (pulse)
- rd_cmd  in  4  read engine cmd
- rd_addr  in  ADDR_W  read engine address
- rd_bank  in  BANK_W  read engine bank
- rd_en  out  1  read grant (1-cycle pulse)
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  decoded command pins
- sdram_addr  out  ADDR_W  muxed address
- sdram_bank  out  BANK_W  muxed bank
- busy_state  out  3  one-hot-free state code: INIT=0, ARBIT=1, AREF=2, WRITE=3, READ=4
- err_timeout  out  1  sticky; a service state exceeded BUSY_MAX

Behaviour:
- Reset values: state=INIT; aref_en, wr_en and rd_en = 0; err_timeout=0; last_grant=READ; busy counter=0.
- Reset applied mid-operation returns to INIT on the next edge. No end pulse is awaited.
- State transitions are registered:
  - INIT -> ARBIT when init_end=1.
  - ARBIT, with aref_req=1 -> AREF.
  - ARBIT, else if wr_req and rd_req are both 1 -> the engine opposite last_grant.
  - ARBIT, else if wr_req=1 -> WRITE.
  - ARBIT, else if rd_req=1 -> READ.
  - ARBIT, else stay in ARBIT.
  - AREF -> ARBIT on aref_end. WRITE -> ARBIT on wr_end. READ -> ARBIT on rd_end.
- Grant pulses:
  - aref_en, wr_en and rd_en are registered and high only during the first cycle in their target state.
  - last_grant updates on entry to WRITE or READ.
- The minimum gap between one end pulse and the next grant is 1 ARBIT cycle. No grant is issued in the same cycle as an end pulse.
- A request arriving in the same cycle as another engine's end pulse is resolved in the following ARBIT cycle by normal priority.
- End pulses from a non-granted engine are ignored.
- Refresh never preempts an active WRITE or READ. The writer/reader observes aref_req directly and terminates its own segment.
- Mux is combinational on the registered state:
  - INIT -> init_cmd/init_addr, bank=0.
  - AREF -> aref_cmd/aref_addr, bank=0.
  - WRITE -> wr_cmd/wr_addr/wr_bank.
  - READ -> rd_cmd/rd_addr/rd_bank.
  - ARBIT -> NOP 4'b0111, addr=0, bank=0.
  - The pins are the muxed 4-bit cmd bits, MSB first: cs_n, ras_n, cas_n, we_n.
- Mux latency is 0 cycles. The engines' own registered commands reach the pins in the cycle they are issued.
- Busy counter:
  - Clears on entry to any service state (AREF, WRITE, READ).
  - Increments each cycle in a service state, saturating at BUSY_MAX.
  - At BUSY_MAX, err_timeout is set. It clears only on rst.
  - The state does not change because of the timeout.

Test Plan:
- Reset/init: rst high 3 cycles, then init_cmd=4'b0010 and init_addr=12'h400 -> pins show 0,0,1,0 and addr 12'h400. Pulse init_end -> state=ARBIT next cycle; pins show NOP 0111.
- Single write: wr_req=1 -> wr_en high exactly 1 cycle, state=WRITE. wr_cmd=4'b0100, wr_addr=12'h01C -> pins 0,1,0,0 and addr 12'h01C in the same cycle. wr_end pulse -> ARBIT, wr_en stays 0.
- Priority: aref_req, wr_req and rd_req all high in ARBIT -> aref_en pulses first. After aref_end -> WRITE, since last_grant=READ after reset. After wr_end -> READ.
- Alternation: wr_req and rd_req held high for 4 grants -> grant order W, R, W, R, each separated by 1 ARBIT cycle.
- No preemption: aref_req rises 10 cycles into WRITE -> no aref_en until wr_end. aref_en follows 1 cycle after returning to ARBIT.
- Timeout/reset: with BUSY_MAX=15, stay in READ 20 cycles -> err_timeout=1 at the 15th cycle, state remains READ. Assert rst -> INIT, err_timeout=0, all enables 0.
